instr_fetch_unit: RTL and testbench

//   Upstream stage of the Main_Decoder: owns the PC, fetches 32-bit instructions over a
//   req/rvalid instruction-memory port and holds each in an instruction register.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/pc_next_logic.sv | 28 ++
 rtl/instr_fetch_unit.sv | 104 ++++++++++
 tb/tb_instr_fetch_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - fetch FSM states, NOP encoding and opcodes shared with Main_Decoder
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          OPCODE_W  = 7;

    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - next-PC select (flush / branch target / +4) and pc+4 adder
module pc_next_logic #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    input  logic            pc_src_i,
    input  logic [XLEN-1:0] pc_target_i,
    output logic [XLEN-1:0] pc_d_o,
    output logic [XLEN-1:0] pc_plus4_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    assign pc_plus4_o = pc_i + XLEN'(4);

    // Redirect targets are word-aligned by masking so pc[1:0] never leaves zero.
    always_comb begin
        pc_d_o = pc_plus4_o;
        if (flush_i) begin
            pc_d_o = flush_pc_i & ALIGN_MASK;
        end else if (pc_src_i) begin
            pc_d_o = pc_target_i & ALIGN_MASK;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and single-outstanding instruction fetch stage
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [31:0]         instr,
    output logic [OPCODE_W-1:0] op,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4,
    input  logic                pc_src,
    input  logic [XLEN-1:0]     pc_target,
    input  logic                flush,
    input  logic [XLEN-1:0]     flush_pc
);

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] fetch_addr_q;
    logic [31:0]     instr_q;
    logic            req_q;
    logic            valid_q;

    pc_next_logic #(.XLEN(XLEN)) u_pc_next (
        .pc_i        (pc_q),
        .flush_i     (flush),
        .flush_pc_i  (flush_pc),
        .pc_src_i    (pc_src),
        .pc_target_i (pc_target),
        .pc_d_o      (pc_d),
        .pc_plus4_o  (pc_plus4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            instr_q      <= NOP_INSTR;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end
                REQ: begin
                    fetch_addr_q <= pc_q;
                    if (flush) begin
                        // A flush with data in the same cycle lets us reissue at once;
                        // otherwise the in-flight response still has to be drained.
                        pc_q    <= pc_d;
                        state_q <= imem_rvalid ? REQ : DROP;
                    end else if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        state_q <= VALID;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                VALID: begin
                    if (flush || instr_ready) begin
                        pc_q    <= pc_d;
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                DROP: begin
                    if (flush) begin
                        pc_q <= pc_d;
                    end
                    if (imem_rvalid) begin
                        state_q <= REQ;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = (state_q == DROP) ? fetch_addr_q : pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign op          = instr_q[OPCODE_W-1:0];
    assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        flush;
    logic [31:0] flush_pc;

    int n_chk  = 0;
    int n_fail = 0;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .op          (op),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .flush       (flush),
        .flush_pc    (flush_pc)
    );

    always #5 clk = ~clk;

    // Reference model: tracks whether a request is outstanding, whether its
    // response is stale, and whether an instruction is being held.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_have;
    logic        m_out;
    logic        m_stale;
    logic [31:0] m_stale_addr;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h13; m_have = 0; m_out = 0; m_stale = 0; m_stale_addr = 0;
    endtask

    task automatic model_step(input logic rv, input logic [31:0] rd, input logic rdy,
                              input logic src, input logic [31:0] tgt,
                              input logic fl, input logic [31:0] fpc);
        if (m_out && !m_stale) begin
            if (fl) begin
                if (!rv) begin
                    m_stale = 1;
                    m_stale_addr = m_pc;
                end
                m_pc = fpc & 32'hFFFF_FFFC;
            end else if (rv) begin
                m_instr = rd; m_have = 1; m_out = 0;
            end
        end else if (m_out) begin
            if (fl) m_pc = fpc & 32'hFFFF_FFFC;
            if (rv) m_stale = 0;
        end else if (m_have) begin
            if (fl) begin
                m_pc = fpc & 32'hFFFF_FFFC; m_have = 0; m_out = 1;
            end else if (rdy) begin
                m_pc = src ? (tgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
                m_have = 0; m_out = 1;
            end
        end else begin
            m_out = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_out});
        chk("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("instr", instr, m_instr);
        chk("op", {25'b0, op}, {25'b0, m_instr[6:0]});
    endtask

    task automatic cyc(input logic rv, input logic [31:0] rd, input logic rdy,
                       input logic src, input logic [31:0] tgt,
                       input logic fl, input logic [31:0] fpc);
        imem_rvalid = rv; imem_rdata = rd; instr_ready = rdy;
        pc_src = src; pc_target = tgt; flush = fl; flush_pc = fpc;
        @(posedge clk);
        model_step(rv, rd, rdy, src, tgt, fl, fpc);
        #1;
        check_model();
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 32'h33, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h13};
        tbl[1] = '{1'b1, 32'h33, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'h33};
        tbl[2] = '{1'b1, 32'h13, 1'b1, 1'b1, 32'h4, 1'b0, 32'h4, 32'h33};
        tbl[3] = '{1'b1, 32'h13, 1'b1, 1'b0, 32'h4, 1'b1, 32'h4, 32'h13};
        tbl[4] = '{1'b1, 32'h03, 1'b1, 1'b1, 32'h8, 1'b0, 32'h8, 32'h13};
        tbl[5] = '{1'b1, 32'h03, 1'b1, 1'b0, 32'h8, 1'b1, 32'h8, 32'h03};

        rst_n = 0; imem_rvalid = 0; imem_rdata = 0; instr_ready = 0;
        pc_src = 0; pc_target = 0; flush = 0; flush_pc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        check_model();

        // Reset asserted while a request is outstanding
        cyc(0, 32'h0, 0, 0, 0, 0, 0);
        chk("pre_reset_req", {31'b0, imem_req}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        check_model();

        // Zero-wait memory, sequential fetch
        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].rv, tbl[i].rd, tbl[i].rdy, 0, 0, 0, 0);
            chk("tbl_req", {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            chk("tbl_addr", imem_addr, tbl[i].e_addr);
            chk("tbl_valid", {31'b0, instr_valid}, {31'b0, tbl[i].e_valid});
            chk("tbl_pc", pc, tbl[i].e_pc);
            chk("tbl_op", {25'b0, op}, {25'b0, tbl[i].e_instr[6:0]});
        end

        // Wait states: request held stable until rvalid
        cyc(1, 32'h0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 32'hBAD0_0000, 0, 0, 0, 0, 0);
            chk("wait_req", {31'b0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'hC);
        end
        cyc(1, 32'h00A0_0093, 0, 0, 0, 0, 0);
        chk("wait_instr", instr, 32'h00A0_0093);

        // Backpressure: held instruction, no new request, stray rvalid ignored
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'hFFFF_FFFF, 0, 1, 32'h100, 0, 0);
            chk("bp_pc", pc, 32'hC);
            chk("bp_req", {31'b0, imem_req}, 32'd0);
            chk("bp_instr", instr, 32'h00A0_0093);
        end

        // Redirect to 0x10, then taken branch to misaligned 0x43
        cyc(0, 0, 0, 0, 0, 1, 32'h12);
        chk("flush_valid_addr", imem_addr, 32'h10);
        cyc(1, 32'h0000_006F, 0, 0, 0, 0, 0);
        chk("pc_at_10", pc, 32'h10);
        cyc(0, 0, 1, 1, 32'h43, 0, 0);
        chk("branch_addr", imem_addr, 32'h40);
        chk("branch_plus4", pc_plus4, 32'h44);

        // Flush in REQ without data: old fetch drained, then refetch at 0x200
        cyc(0, 0, 0, 0, 0, 1, 32'h200);
        chk("drop_req", {31'b0, imem_req}, 32'd1);
        chk("drop_addr", imem_addr, 32'h40);
        chk("drop_pc", pc, 32'h200);
        cyc(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        chk("drop_discard", instr, 32'h0000_006F);
        chk("refetch_addr", imem_addr, 32'h200);
        cyc(1, 32'h13, 0, 0, 0, 0, 0);
        chk("refetch_pc", pc, 32'h200);

        // PC wrap at top of address space
        cyc(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1, 32'h33, 0, 0, 0, 0, 0);
        chk("wrap_plus4", pc_plus4, 32'h0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("wrap_next", imem_addr, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom,
                ($urandom_range(0, 7) == 0), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
